// File: rtl/visor_rx_fifo_if.sv
// visor_rx_fifo_if
//  Bundles the UART-side capture inputs and the visor register-file read side of
//  visor_rx_fifo.
//  slave  : the FIFO (consumes rx_*, pop, clr_overflow; drives rd_data/rd_status)
//  master : the surrounding logic / testbench driving it
interface visor_rx_fifo_if;
  logic        rx_busy_async;  // uart rx_busy, clk_async domain
  logic [7:0]  rx_data_async;  // uart parallel_out, quasi-static while idle
  logic        pop;            // read strobe of the data register
  logic        clr_overflow;   // clears sticky overflow
  logic [15:0] rd_data;        // {8'h00, head} or 0 when empty
  logic [15:0] rd_status;      // {3'b0, count, 5'b0, overflow, full, not_empty}

  modport slave (
    input  rx_busy_async, rx_data_async, pop, clr_overflow,
    output rd_data, rd_status
  );
  modport master (
    output rx_busy_async, rx_data_async, pop, clr_overflow,
    input  rd_data, rd_status
  );
endinterface

// File: rtl/visor_rx_fifo.sv
// visor_rx_fifo
//  Receive buffer between the debug UART receiver (clk_async) and the visor
//  register file (sysclk). A synced falling edge of rx_busy marks a completed
//  frame; the byte is then captured into a register-based FWFT FIFO.
//  Ports:
//   sysclk   : system clock
//   sysreset : asynchronous, active-high reset
//   bus      : visor_rx_fifo_if.slave (rx_busy/rx_data in, pop/clr_overflow in,
//              rd_data/rd_status out)
module visor_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic            sysclk,
  input logic            sysreset,
  visor_rx_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_pipe_q;
  logic                   busy_q;
  logic                   armed_q, armed_d;
  logic                   ovf_q, ovf_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [DEPTH-1:0][7:0]  mem_q;

  logic sync, rise, fall, push, full, not_empty, do_pop, do_push, ovf_set;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);

  // The sync chain and busy_q reset to 0, so a frame already in progress at
  // reset release would look like a rising edge once the chain fills. Edges
  // are only trusted after vld_pipe_q has shifted a 1 all the way through,
  // i.e. once busy_q holds a genuinely sampled value.
  assign rise = vld_pipe_q[SYNC_STAGES] &  sync & ~busy_q;
  assign fall = vld_pipe_q[SYNC_STAGES] & ~sync &  busy_q;
  assign push = fall & armed_q;

  // A pop on a full FIFO frees the slot the push then reuses.
  assign do_pop  = bus.pop & not_empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  always_comb begin
    armed_d  = armed_q | rise;
    ovf_d    = ovf_set ? 1'b1 : (bus.clr_overflow ? 1'b0 : ovf_q);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.rx_busy_async};
      vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
      busy_q     <= sync;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked by count.
  // rx_data_async is quasi-static on the push cycle by the UART contract.
  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.rx_data_async;
  end

  assign bus.rd_data   = not_empty ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
  assign bus.rd_status = {3'b000, count_q, 5'b00000, ovf_q, full, not_empty};

endmodule

// File: tb/tb_visor_rx_fifo.sv
module tb_visor_rx_fifo;
  localparam int SYNC_STAGES = 2;

  logic sysclk = 1'b0;
  logic sysreset;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] exp_q[$];

  visor_rx_fifo_if bus();

  visor_rx_fifo #(.DEPTH(16), .AW(4), .SYNC_STAGES(SYNC_STAGES)) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Check the scoreboard head against rd_data, then pop it.
  task automatic chk_head(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s: scoreboard empty, rd_data %h", tag, bus.rd_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.rd_data, {8'h00, e});
    end
  endtask

  task automatic do_pop(input string tag);
    chk_head(tag);
    bus.pop = 1'b1;
    @(negedge sysclk);
    bus.pop = 1'b0;
  endtask

  // One UART frame. Inputs change on negedges; the push edge is the third
  // posedge after rx_busy falls, so pop/clr driven two negedges after the
  // fall land exactly on the push cycle.
  task automatic frame(input logic [7:0] b, input bit queued, input bit pop_on, input bit clr_on);
    bus.rx_busy_async = 1'b1;
    bus.rx_data_async = b;
    repeat (6) @(negedge sysclk);
    bus.rx_busy_async = 1'b0;
    repeat (2) @(negedge sysclk);
    if (pop_on) begin
      chk_head("pop_on_push_head");
      bus.pop = 1'b1;
    end
    if (clr_on) bus.clr_overflow = 1'b1;
    @(negedge sysclk);
    bus.pop = 1'b0;
    bus.clr_overflow = 1'b0;
    if (queued) exp_q.push_back(b);
    repeat (SYNC_STAGES - 1) @(negedge sysclk);
  endtask

  initial begin
    sysreset          = 1'b1;
    bus.rx_busy_async = 1'b1;
    bus.rx_data_async = 8'h5A;
    bus.pop           = 1'b0;
    bus.clr_overflow  = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("reset_data", bus.rd_data, 16'h0000);
    chk("reset_status", bus.rd_status, 16'h0000);

    // 1: frame in flight at reset release is never queued
    sysreset = 1'b0;
    repeat (8) @(negedge sysclk);
    bus.rx_busy_async = 1'b0;
    repeat (6) @(negedge sysclk);
    chk("t1_status", bus.rd_status, 16'h0000);

    // 2: single frame, visible within SYNC_STAGES+2 cycles of the fall
    frame(8'h41, 1'b1, 1'b0, 1'b0);
    chk("t2_status", bus.rd_status, 16'h0101);
    do_pop("t2_pop");
    chk("t2_status_after", bus.rd_status, 16'h0000);

    // 3: 17 frames, last is dropped and overflow sticks
    for (int i = 0; i < 17; i++) frame(8'(i), i < 16, 1'b0, 1'b0);
    chk("t3_status_full", bus.rd_status, 16'h1007);
    for (int i = 0; i < 16; i++) do_pop("t3_pop");
    chk("t3_status_drained", bus.rd_status, 16'h0004);
    bus.clr_overflow = 1'b1;
    @(negedge sysclk);
    bus.clr_overflow = 1'b0;
    chk("t3_clr", bus.rd_status, 16'h0000);

    // 4: full FIFO, pop coincides with push
    for (int i = 0; i < 16; i++) frame(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("t4_full", bus.rd_status, 16'h1003);
    frame(8'hB0, 1'b1, 1'b1, 1'b0);
    chk("t4_after", bus.rd_status, 16'h1003);
    for (int i = 0; i < 16; i++) do_pop("t4_pop");
    chk("t4_empty", bus.rd_status, 16'h0000);

    // 5: overflow set beats a coincident clear
    for (int i = 0; i < 16; i++) frame(8'h60 + 8'(i), 1'b1, 1'b0, 1'b0);
    frame(8'h77, 1'b0, 1'b0, 1'b1);
    chk("t5_set_wins", bus.rd_status, 16'h1007);
    bus.clr_overflow = 1'b1;
    @(negedge sysclk);
    bus.clr_overflow = 1'b0;
    chk("t5_clr", bus.rd_status, 16'h1003);
    for (int i = 0; i < 16; i++) do_pop("t5_pop");
    chk("t5_empty", bus.rd_status, 16'h0000);

    // 6: pop while empty is ignored
    bus.pop = 1'b1;
    repeat (3) @(negedge sysclk);
    bus.pop = 1'b0;
    chk("t6_status", bus.rd_status, 16'h0000);
    chk("t6_data", bus.rd_data, 16'h0000);
    frame(8'hC3, 1'b1, 1'b0, 1'b0);
    chk("t6_status_one", bus.rd_status, 16'h0101);
    do_pop("t6_pop");
    chk("t6_final", bus.rd_status, 16'h0000);
    if (exp_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
